// File: rtl/fht_io_ctrl_pkg.sv
// Shared definitions for the FHT I/O controller and FHT control:
//   state_t  - I/O controller FSM state encoding
//   calc_n   - points per frame from the bank address width (4 banks)
//   bit_rev  - reverse the low w bits of a value (also used for coefficient
//              index reversal in fht_control)
package fht_io_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_ARM,
    ST_WAIT,
    ST_UNLOAD,
    ST_DRAIN
  } state_t;

  localparam int BANKS      = 4;
  localparam int FIFO_DEPTH = 4;

  function automatic int calc_n(input int a_bit);
    return BANKS << a_bit;
  endfunction

  // Bits of v above w are ignored; the result is zero above bit w-1.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] src;
    logic [31:0] res;
    src = v;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        res = {res[30:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fht_io_fifo.sv
// 4-entry output FIFO holding {last, data} result words.
// Ports:
//   iCLK    clock
//   iRESET  synchronous active-low reset (empties the FIFO, clears storage)
//   iPUSH   write iDATA (caller guarantees the FIFO is not full)
//   iDATA   word to store
//   iPOP    remove head word when oVALID is high
//   oDATA   head word
//   oVALID  FIFO not empty (registered)
//   oCOUNT  occupancy 0..4 (registered)
module fht_io_fifo
  import fht_io_ctrl_pkg::*;
#(
  parameter int DATA_W = 17
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iPUSH,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iPOP,
  output logic [DATA_W-1:0] oDATA,
  output logic              oVALID,
  output logic [2:0]        oCOUNT
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic              do_pop;
  logic [2:0]        cnt_nxt;

  assign do_pop = iPOP & oVALID;
  assign oDATA  = mem[rd_ptr];

  // Simultaneous push and pop leaves occupancy unchanged.
  always_comb begin
    cnt_nxt = oCOUNT;
    if (iPUSH && !do_pop)
      cnt_nxt = oCOUNT + 3'd1;
    else if (!iPUSH && do_pop)
      cnt_nxt = oCOUNT - 3'd1;
  end

  // Storage is cleared on reset so the data output reads zero afterwards.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      oCOUNT <= '0;
      oVALID <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (iPUSH) begin
        mem[wr_ptr] <= iDATA;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 2'd1;
      oCOUNT <= cnt_nxt;
      oVALID <= (cnt_nxt != 3'd0);
    end
  end

endmodule

// File: rtl/fht_io_ctrl.sv
// FHT I/O controller: loads a frame of N samples into four banks in
// bit-reversed order, starts the FHT, then streams the result back out in
// natural order through a 4-entry FIFO.
// Ports:
//   iCLK, iRESET                 clock, synchronous active-low reset
//   iIN_VALID/oIN_READY/iIN_DATA input sample stream (natural order)
//   oOUT_VALID/iOUT_READY        result stream handshake
//   oOUT_DATA/oOUT_LAST          result word, marks index N-1
//   oSTART/iRDY                  start pulse to / ready from FHT control
//   iRES_B                       result lives in bank set B
//   oWE/oADDR_WR/oDATA_WR        bank write port (one-hot bank enable)
//   oADDR_RD/oSEL_B              bank read address and set select
//   iDATA_RD_0..3                bank read data, two cycles after issue
//   oBUSY                        high whenever not idle
module fht_io_ctrl
  import fht_io_ctrl_pkg::*;
#(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iIN_VALID,
  output logic             oIN_READY,
  input  logic [D_BIT-1:0] iIN_DATA,
  output logic             oOUT_VALID,
  input  logic             iOUT_READY,
  output logic [D_BIT-1:0] oOUT_DATA,
  output logic             oOUT_LAST,
  output logic             oSTART,
  input  logic             iRDY,
  input  logic             iRES_B,
  output logic [3:0]       oWE,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic [A_BIT-1:0] oADDR_RD,
  output logic             oSEL_B,
  input  logic [D_BIT-1:0] iDATA_RD_0,
  input  logic [D_BIT-1:0] iDATA_RD_1,
  input  logic [D_BIT-1:0] iDATA_RD_2,
  input  logic [D_BIT-1:0] iDATA_RD_3,
  output logic             oBUSY
);

  localparam int N  = calc_n(A_BIT);
  localparam int KW = A_BIT + 2;
  localparam logic [KW-1:0] LAST_IDX = KW'(N - 1);

  state_t          state;
  logic [KW-1:0]   k;
  logic [KW-1:0]   j;
  logic [KW-1:0]   rev_k;

  logic            vld_p0, vld_p1;
  logic [1:0]      bank_p0, bank_p1;
  logic            last_p0, last_p1;
  logic [D_BIT-1:0] rd_mux;
  logic [2:0]      fifo_cnt;
  logic [3:0]      owned;

  assign rev_k = KW'(bit_rev(32'(k), KW));

  // Words queued plus reads in flight; a new read is issued only if its
  // word is guaranteed a FIFO slot, so the FIFO can never overflow.
  assign owned = {1'b0, fifo_cnt} + {3'b0, vld_p0} + {3'b0, vld_p1};

  always_comb begin
    rd_mux = iDATA_RD_0;
    case (bank_p1)
      2'd0: rd_mux = iDATA_RD_0;
      2'd1: rd_mux = iDATA_RD_1;
      2'd2: rd_mux = iDATA_RD_2;
      2'd3: rd_mux = iDATA_RD_3;
      default: rd_mux = iDATA_RD_0;
    endcase
  end

  // Stage p1 -> FIFO: read data for the bank recorded at issue
  fht_io_fifo #(.DATA_W(D_BIT + 1)) u_fifo (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iPUSH  (vld_p1),
    .iDATA  ({last_p1, rd_mux}),
    .iPOP   (iOUT_READY),
    .oDATA  ({oOUT_LAST, oOUT_DATA}),
    .oVALID (oOUT_VALID),
    .oCOUNT (fifo_cnt)
  );

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state     <= ST_IDLE;
      k         <= '0;
      j         <= '0;
      oIN_READY <= 1'b0;
      oWE       <= '0;
      oADDR_WR  <= '0;
      oDATA_WR  <= '0;
      oSTART    <= 1'b0;
      oADDR_RD  <= '0;
      oSEL_B    <= 1'b0;
      oBUSY     <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      bank_p0   <= '0;
      bank_p1   <= '0;
      last_p0   <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      oWE    <= '0;
      oSTART <= 1'b0;
      // Stage p0 -> p1: read issued last cycle moves one step along
      vld_p0  <= 1'b0;
      vld_p1  <= vld_p0;
      bank_p1 <= bank_p0;
      last_p1 <= last_p0;

      case (state)
        ST_IDLE: begin
          if (iIN_VALID && iRDY) begin
            state     <= ST_LOAD;
            oIN_READY <= 1'b1;
            oBUSY     <= 1'b1;
            k         <= '0;
          end
        end
        ST_LOAD: begin
          if (iIN_VALID) begin
            oWE      <= 4'b0001 << rev_k[1:0];
            oADDR_WR <= rev_k[KW-1:2];
            oDATA_WR <= iIN_DATA;
            k        <= k + 1'b1;
            if (k == LAST_IDX) begin
              state     <= ST_START;
              oIN_READY <= 1'b0;
              oSTART    <= 1'b1;
            end
          end
        end
        ST_START: state <= ST_ARM;
        // iRDY must drop first so a stale "done" is not mistaken for completion.
        ST_ARM: begin
          if (!iRDY)
            state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (iRDY) begin
            state  <= ST_UNLOAD;
            oSEL_B <= iRES_B;
            j      <= '0;
          end
        end
        // Stage issue -> p0: natural-order read of index j
        ST_UNLOAD: begin
          if (owned < 4'd4) begin
            oADDR_RD <= j[KW-1:2];
            vld_p0   <= 1'b1;
            bank_p0  <= j[1:0];
            last_p0  <= (j == LAST_IDX);
            j        <= j + 1'b1;
            if (j == LAST_IDX)
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!oOUT_VALID && !vld_p0 && !vld_p1) begin
            state  <= ST_IDLE;
            oBUSY  <= 1'b0;
            oSEL_B <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_io_ctrl.sv
module tb_fht_io_ctrl;
  localparam int A_BIT = 2;
  localparam int D_BIT = 16;
  localparam int N     = 16;

  logic             iCLK = 1'b0;
  logic             iRESET = 1'b0;
  logic             iIN_VALID = 1'b0;
  logic             oIN_READY;
  logic [D_BIT-1:0] iIN_DATA = '0;
  logic             oOUT_VALID;
  logic             iOUT_READY = 1'b1;
  logic [D_BIT-1:0] oOUT_DATA;
  logic             oOUT_LAST;
  logic             oSTART;
  logic             iRDY = 1'b1;
  logic             iRES_B = 1'b0;
  logic [3:0]       oWE;
  logic [A_BIT-1:0] oADDR_WR;
  logic [D_BIT-1:0] oDATA_WR;
  logic [A_BIT-1:0] oADDR_RD;
  logic             oSEL_B;
  logic [D_BIT-1:0] rd [4];
  logic             oBUSY;

  fht_io_ctrl #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET),
    .iIN_VALID(iIN_VALID), .oIN_READY(oIN_READY), .iIN_DATA(iIN_DATA),
    .oOUT_VALID(oOUT_VALID), .iOUT_READY(iOUT_READY),
    .oOUT_DATA(oOUT_DATA), .oOUT_LAST(oOUT_LAST),
    .oSTART(oSTART), .iRDY(iRDY), .iRES_B(iRES_B),
    .oWE(oWE), .oADDR_WR(oADDR_WR), .oDATA_WR(oDATA_WR),
    .oADDR_RD(oADDR_RD), .oSEL_B(oSEL_B),
    .iDATA_RD_0(rd[0]), .iDATA_RD_1(rd[1]), .iDATA_RD_2(rd[2]), .iDATA_RD_3(rd[3]),
    .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rev4(input int v);
    int r = 0;
    for (int i = 0; i < 4; i++)
      if ((v & (1 << i)) != 0) r = r | (1 << (3 - i));
    return r;
  endfunction

  // Bank sets: A receives the DUT's writes, B stands in for the FHT result.
  logic [D_BIT-1:0] memA [4][4];
  logic [D_BIT-1:0] memB [4][4];
  initial begin
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++) begin
        memB[b][a] = D_BIT'(16 * b + a);
        memA[b][a] = '0;
      end
  end

  // Synchronous read: address seen at edge e, data visible until edge e+1.
  always @(posedge iCLK) begin
    for (int b = 0; b < 4; b++) begin
      if (oWE[b]) memA[b][oADDR_WR] <= oDATA_WR;
      rd[b] <= oSEL_B ? memB[b][oADDR_RD] : memA[b][oADDR_RD];
    end
  end

  // ---------------- reference model + compare process ----------------
  // phase: 0 idle, 1 load, 2 start, 3 arm, 4 wait, 5 unload/drain
  int               mph = 0;
  int               mk = 0;
  int               m_pops = 0;
  int               m_cyc = 0;
  bit               m_sel = 1'b0;
  logic [D_BIT-1:0] msamp [N];
  logic [D_BIT-1:0] q [$];
  bit               hold_rdy = 1'b0;

  bit               e_zero = 1'b1;
  bit               e_in_ready = 1'b0;
  bit               e_start = 1'b0;
  bit               e_busy = 1'b0;
  logic [3:0]       e_we = '0;
  logic [1:0]       e_addr_wr = '0;
  logic [D_BIT-1:0] e_data_wr = '0;
  int               e_lit_k = -1;

  always @(negedge iCLK) begin
    int r;
    chk("in_ready", 32'(oIN_READY), 32'(e_in_ready));
    chk("start", 32'(oSTART), 32'(e_start));
    chk("busy", 32'(oBUSY), 32'(e_busy));
    chk("we", 32'(oWE), 32'(e_we));
    if (e_we != 4'd0) begin
      chk("addr_wr", 32'(oADDR_WR), 32'(e_addr_wr));
      chk("data_wr", 32'(oDATA_WR), 32'(e_data_wr));
    end
    if (e_lit_k == 1) begin
      chk("lit_k1_we", 32'(oWE), 32'h1);
      chk("lit_k1_addr", 32'(oADDR_WR), 32'd2);
    end
    if (e_lit_k == 3) begin
      chk("lit_k3_we", 32'(oWE), 32'h1);
      chk("lit_k3_addr", 32'(oADDR_WR), 32'd3);
    end
    if (e_lit_k == 6) begin
      chk("lit_k6_we", 32'(oWE), 32'h4);
      chk("lit_k6_addr", 32'(oADDR_WR), 32'd1);
    end
    if (e_zero) begin
      chk("rst_out_valid", 32'(oOUT_VALID), 32'd0);
      chk("rst_out_data", 32'(oOUT_DATA), 32'd0);
      chk("rst_out_last", 32'(oOUT_LAST), 32'd0);
      chk("rst_addr_wr", 32'(oADDR_WR), 32'd0);
      chk("rst_data_wr", 32'(oDATA_WR), 32'd0);
      chk("rst_addr_rd", 32'(oADDR_RD), 32'd0);
      chk("rst_sel_b", 32'(oSEL_B), 32'd0);
    end
    if (mph == 0) chk("idle_out_valid", 32'(oOUT_VALID), 32'd0);
    if (mph == 5 && hold_rdy)
      chk("out_valid_timing", 32'(oOUT_VALID), 32'(m_cyc >= 3 && m_cyc <= 18));

    // advance the model across the coming rising edge
    e_zero  = 1'b0;
    e_we    = '0;
    e_lit_k = -1;
    if (!iRESET) begin
      mph = 0; mk = 0; m_pops = 0; q.delete();
      e_zero = 1'b1;
    end else begin
      case (mph)
        0: if (iIN_VALID && iRDY) begin mph = 1; mk = 0; end
        1: if (iIN_VALID) begin
             r = rev4(mk);
             e_we      = 4'(1 << (r % 4));
             e_addr_wr = 2'(r / 4);
             e_data_wr = iIN_DATA;
             msamp[mk] = iIN_DATA;
             e_lit_k   = mk;
             if (mk == N - 1) begin mph = 2; mk = 0; end
             else mk++;
           end
        2: mph = 3;
        3: if (!iRDY) mph = 4;
        4: if (iRDY) begin
             mph = 5; m_sel = iRES_B; m_cyc = 0; m_pops = 0; q.delete();
             for (int jj = 0; jj < N; jj++)
               q.push_back(iRES_B ? memB[jj % 4][jj / 4] : msamp[rev4(jj)]);
           end
        5: begin
             m_cyc++;
             if (m_pops == N) begin
               chk("extra_word", 32'(oOUT_VALID), 32'd0);
               mph = 0;
             end else if (oOUT_VALID && iOUT_READY) begin
               chk("out_data", 32'(oOUT_DATA), 32'(q[0]));
               chk("out_last", 32'(oOUT_LAST), 32'(m_pops == N - 1));
               chk("sel_b", 32'(oSEL_B), 32'(m_sel));
               if (m_sel) begin
                 if (m_pops == 0)  chk("lit_j0", 32'(oOUT_DATA), 32'd0);
                 if (m_pops == 1)  chk("lit_j1", 32'(oOUT_DATA), 32'd16);
                 if (m_pops == 4)  chk("lit_j4", 32'(oOUT_DATA), 32'd1);
                 if (m_pops == 15) chk("lit_j15", 32'(oOUT_DATA), 32'd51);
               end
               void'(q.pop_front());
               m_pops++;
             end
           end
        default: mph = 0;
      endcase
    end
    e_in_ready = (mph == 1);
    e_start    = (mph == 2);
    e_busy     = (mph != 0);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge iCLK); #1;
  endtask

  task automatic load_frame(input int nsamp, input bit rnd_valid, input bit seq_data);
    int idx = 0;
    int guard = 0;
    bit fire;
    iIN_DATA = seq_data ? '0 : D_BIT'($urandom);
    while (idx < nsamp && guard < 2000) begin
      iIN_VALID = rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge iCLK);
      fire = iIN_VALID && oIN_READY;
      cyc();
      guard++;
      if (fire) begin
        idx++;
        iIN_DATA = seq_data ? D_BIT'(idx) : D_BIT'($urandom);
      end
    end
    iIN_VALID = 1'b0;
    chk("load_accepted", 32'(idx), 32'(nsamp));
  endtask

  task automatic compute_phase(input bit resb, input int low_cycles, input bit hold);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge iCLK);
      if (oSTART) seen = 1'b1;
    end
    chk("start_seen", 32'(seen), 32'd1);
    cyc();
    iRDY = 1'b0;
    repeat (low_cycles) cyc();
    iRES_B     = resb;
    hold_rdy   = hold;
    iOUT_READY = 1'b1;
    iRDY       = 1'b1;
  endtask

  // mode 0: ready held high, 1: random ready, 2: stall 10 cycles after 5 words
  task automatic unload(input int mode);
    int guard = 0;
    int pops = 0;
    bit fire;
    bit done = 1'b0;
    if (mode == 1) iOUT_READY = ($urandom_range(0, 1) == 1);
    while (guard < 400 && !done) begin
      @(negedge iCLK);
      fire = oOUT_VALID && iOUT_READY;
      if (!oBUSY) done = 1'b1;
      else begin
        cyc();
        guard++;
        if (fire) pops++;
        if (mode == 1) iOUT_READY = ($urandom_range(0, 1) == 1);
        if (mode == 2 && fire && pops == 5) begin
          iOUT_READY = 1'b0;
          repeat (10) begin
            @(negedge iCLK);
            chk("stall_hold_valid", 32'(oOUT_VALID), 32'd1);
            cyc();
          end
          iOUT_READY = 1'b1;
        end
      end
    end
    hold_rdy   = 1'b0;
    iOUT_READY = 1'b1;
    chk("drain_done", 32'(done), 32'd1);
    chk("pop_count", 32'(pops), 32'(N));
  endtask

  task automatic frame(input bit rnd_valid, input bit seq_data, input bit resb,
                       input int low_cycles, input int mode);
    load_frame(N, rnd_valid, seq_data);
    compute_phase(resb, low_cycles, mode == 0);
    unload(mode);
  endtask

  initial begin
    iRESET = 1'b0;
    repeat (2) cyc();
    iRESET = 1'b1;
    cyc();

    // FHT control busy while data is offered: nothing may be accepted
    iRDY = 1'b0;
    iIN_VALID = 1'b1;
    repeat (6) cyc();
    iIN_VALID = 1'b0;
    iRDY = 1'b1;
    cyc();

    frame(1'b0, 1'b1, 1'b1, 5, 0);   // sequential data, result in set B
    frame(1'b1, 1'b1, 1'b0, 3, 0);   // 50% valid, result in set A
    frame(1'b0, 1'b0, 1'b1, 2, 2);   // downstream stall mid-unload

    // reset partway through a load, then a clean frame
    load_frame(7, 1'b0, 1'b1);
    iRESET = 1'b0;
    cyc();
    iRESET = 1'b1;
    cyc();
    frame(1'b1, 1'b0, 1'b0, 4, 1);

    for (int f = 0; f < 2; f++)
      frame(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 6), 1);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
